// File: rtl/msg_byte_serializer.sv
// Message FIFO feeding a byte shifter: whole MSG_BITS words go in, a valid/ready
// byte stream comes out with the final byte of each message flagged.
module msg_byte_serializer #(
    parameter int MSG_BITS   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [MSG_BITS-1:0]           msg_i,
    input  logic                          msg_valid_i,
    output logic                          msg_ready_o,
    output logic [7:0]                    byte_o,
    output logic                          byte_valid_o,
    input  logic                          byte_ready_i,
    output logic                          byte_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          busy_o
);
    localparam int NBYTES   = (MSG_BITS + 7) / 8;
    localparam int PAD_BITS = NBYTES * 8;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [MSG_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    state_t              state_reg;
    logic [PAD_BITS-1:0] data_reg;
    logic [PAD_BITS-1:0] head_pad;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic [7:0]          byte_reg;
    logic                valid_reg;
    logic                last_reg;

    logic [7:0]          head_bytes [NBYTES];
    logic [7:0]          data_bytes [NBYTES];

    logic                push;
    logic                pop;
    logic                handshake;
    logic                last_hs;

    // Head is read combinationally so a new message can follow the last byte with no bubble.
    always_comb begin
        head_pad                 = '0;
        head_pad[MSG_BITS-1:0]   = mem[rd_ptr_reg];
    end

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign head_bytes[gi] = head_pad[8*gi +: 8];
            assign data_bytes[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

    // Maps transmit order k to the byte lane actually sent.
    function automatic logic [IDX_W-1:0] lane(input logic [IDX_W-1:0] k);
        lane = MSB_FIRST ? (IDX_W'(NBYTES - 1) - k) : k;
    endfunction

    assign msg_ready_o  = !rst_i && (count_reg != CNT_W'(FIFO_DEPTH));
    assign push         = msg_valid_i && msg_ready_o;
    assign handshake    = valid_reg && byte_ready_i;
    assign last_hs      = handshake && last_reg;
    assign pop          = (count_reg != '0) && ((state_reg == IDLE) || last_hs);
    assign idx_next     = idx_reg + 1'b1;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= msg_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            idx_reg   <= '0;
            byte_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (pop) begin
            state_reg <= SHIFT;
            data_reg  <= head_pad;
            idx_reg   <= '0;
            byte_reg  <= head_bytes[lane(IDX_W'(0))];
            valid_reg <= 1'b1;
            last_reg  <= (NBYTES == 1);
        end else if (last_hs) begin
            state_reg <= IDLE;
            byte_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (handshake) begin
            idx_reg   <= idx_next;
            byte_reg  <= data_bytes[lane(idx_next)];
            last_reg  <= (idx_next == IDX_W'(NBYTES - 1));
        end
    end

    assign byte_o       = byte_reg;
    assign byte_valid_o = valid_reg;
    assign byte_last_o  = last_reg;
    assign fill_o       = count_reg;
    assign busy_o       = (state_reg == SHIFT);

endmodule

// File: tb/tb_msg_byte_serializer.sv
// Randomized bench for msg_byte_serializer: a 32-bit LSB-first instance and a
// 20-bit MSB-first instance, each checked against a queue of expected bytes.
module tb_msg_byte_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] msg_a = '0;
    logic        vld_a = 1'b0;
    logic        rdy_a_dir = 1'b0;
    logic        rnd_en = 1'b0;
    logic        rnd_bit = 1'b0;
    logic        rdy_a;
    logic        mready_a, bvalid_a, blast_a, busy_a;
    logic [7:0]  byte_a;
    logic [2:0]  fill_a;

    logic [19:0] msg_b = '0;
    logic        vld_b = 1'b0;
    logic        rdy_b = 1'b1;
    logic        mready_b, bvalid_b, blast_b, busy_b;
    logic [7:0]  byte_b;
    logic [2:0]  fill_b;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_a [$];
    logic [8:0] exp_b [$];

    logic       prev_stall_a = 1'b0;
    logic [7:0] prev_byte_a  = '0;
    logic       prev_last_a  = 1'b0;

    assign rdy_a = rnd_en ? rnd_bit : rdy_a_dir;

    always #5 clk = ~clk;

    msg_byte_serializer #(.MSG_BITS(32), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .msg_i(msg_a), .msg_valid_i(vld_a), .msg_ready_o(mready_a),
        .byte_o(byte_a), .byte_valid_o(bvalid_a), .byte_ready_i(rdy_a), .byte_last_o(blast_a),
        .fill_o(fill_a), .busy_o(busy_a)
    );

    msg_byte_serializer #(.MSG_BITS(20), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .msg_i(msg_b), .msg_valid_i(vld_b), .msg_ready_o(mready_b),
        .byte_o(byte_b), .byte_valid_o(bvalid_b), .byte_ready_i(rdy_b), .byte_last_o(blast_b),
        .fill_o(fill_b), .busy_o(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 2) == 0);
    end

    // Expected stream: message bytes in transmit order, last flag on the final one.
    task automatic start_push(input int which, input logic [31:0] m);
        if (which == 0) begin
            msg_a = m;
            vld_a = 1'b1;
            for (int k = 0; k < 4; k++)
                exp_a.push_back({(k == 3), 8'((m >> (8 * k)) & 32'hFF)});
            $display("push a msg=0x%08h", m);
        end else begin
            msg_b = m[19:0];
            vld_b = 1'b1;
            for (int k = 2; k >= 0; k--)
                exp_b.push_back({(k == 0), 8'((m[19:0] >> (8 * k)) & 20'hFF)});
            $display("push b msg=0x%05h", m[19:0]);
        end
    endtask

    task automatic wait_accept(input int which);
        int t = 0;
        while (!((which == 0) ? mready_a : mready_b) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300)
            check_eq("accept_timeout", (which == 0) ? mready_a : mready_b, 1);
        tick();
        if (which == 0) vld_a = 1'b0;
        else            vld_b = 1'b0;
    endtask

    task automatic push(input int which, input logic [31:0] m);
        start_push(which, m);
        wait_accept(which);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && t < 3000) begin
            tick();
            t++;
        end
        check_eq("drain_a_left", exp_a.size(), 0);
        check_eq("drain_b_left", exp_b.size(), 0);
        check_eq("drain_busy_a", busy_a, 0);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            prev_stall_a = 1'b0;
        end else begin
            if (prev_stall_a) begin
                check_eq("a_stall_valid", bvalid_a, 1);
                check_eq("a_stall_byte", byte_a, prev_byte_a);
                check_eq("a_stall_last", blast_a, prev_last_a);
            end
            if (bvalid_a && rdy_a) begin
                if (exp_a.size() == 0) begin
                    check_eq("a_extra_byte", bvalid_a, 0);
                end else begin
                    e = exp_a.pop_front();
                    check_eq("a_byte", byte_a, e[7:0]);
                    check_eq("a_last", blast_a, e[8]);
                    $display("byte a 0x%02h last=%0b", byte_a, blast_a);
                end
            end
            prev_stall_a = bvalid_a && !rdy_a;
            prev_byte_a  = byte_a;
            prev_last_a  = blast_a;
            if (bvalid_b && rdy_b) begin
                if (exp_b.size() == 0) begin
                    check_eq("b_extra_byte", bvalid_b, 0);
                end else begin
                    e = exp_b.pop_front();
                    check_eq("b_byte", byte_b, e[7:0]);
                    check_eq("b_last", blast_b, e[8]);
                    $display("byte b 0x%02h last=%0b", byte_b, blast_b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic accepted;
        logic [31:0] m1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_ready", mready_a, 0);
        check_eq("rst_valid", bvalid_a, 0);
        check_eq("rst_fill", fill_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_byte", byte_a, 0);
        check_eq("rst_last", blast_a, 0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", mready_a, 1);
        tick();

        // Latency and byte order with the sink always ready
        rdy_a_dir = 1'b1;
        push(0, 32'hA1B2C3D4);
        check_eq("lat_valid_n", bvalid_a, 0);
        check_eq("lat_fill_n", fill_a, 1);
        tick();
        check_eq("lat_valid_n1", bvalid_a, 1);
        check_eq("lat_byte0", byte_a, 8'hD4);
        check_eq("lat_busy", busy_a, 1);
        check_eq("lat_fill_n1", fill_a, 0);
        repeat (4) tick();
        check_eq("lat_busy_done", busy_a, 0);
        check_eq("lat_valid_done", bvalid_a, 0);

        // Fill the FIFO behind a stalled shifter
        rdy_a_dir = 1'b0;
        m1 = $urandom;
        push(0, m1);
        for (int i = 0; i < 4; i++) push(0, $urandom);
        check_eq("full_fill", fill_a, 4);
        check_eq("full_ready", mready_a, 0);
        check_eq("full_busy", busy_a, 1);
        check_eq("full_byte", byte_a, {24'h0, m1[7:0]});
        start_push(0, $urandom);
        repeat (2) begin
            tick();
            check_eq("held_ready", mready_a, 0);
            check_eq("held_fill", fill_a, 4);
        end
        rdy_a_dir = 1'b1;
        for (int i = 0; i < 24; i++) begin
            check_eq("gapless_valid", bvalid_a, 1);
            if (i <= 5) check_eq("pop_push_fill", fill_a, (i == 4) ? 3 : 4);
            accepted = vld_a && mready_a;
            tick();
            if (accepted) vld_a = 1'b0;
        end
        check_eq("m6_accepted", vld_a, 0);
        check_eq("burst_end_valid", bvalid_a, 0);
        check_eq("burst_end_busy", busy_a, 0);

        // Random sink stalls
        rnd_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(0, $urandom);
            if ($urandom_range(0, 1) == 1) tick();
        end
        drain();
        rnd_en = 1'b0;

        // Reset in the middle of a message with two more queued
        rdy_a_dir = 1'b0;
        push(0, 32'h11223344);
        push(0, $urandom);
        push(0, $urandom);
        check_eq("mid_fill", fill_a, 2);
        rdy_a_dir = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", mready_a, 0);
        exp_a.delete();
        exp_b.delete();
        tick();
        check_eq("mid_rst_valid", bvalid_a, 0);
        check_eq("mid_rst_fill", fill_a, 0);
        check_eq("mid_rst_busy", busy_a, 0);
        rst = 1'b0;
        #1;
        check_eq("mid_release_ready", mready_a, 1);
        tick();
        push(0, 32'h55667788);
        drain();

        // 20-bit, most-significant byte first
        push(1, 32'h000ABCDE);
        tick();
        check_eq("b_first_byte", byte_b, 8'h0A);
        check_eq("b_first_last", blast_b, 0);
        for (int i = 0; i < 6; i++) push(1, $urandom_range(0, 32'hFFFFF));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
